// File: rtl/vga_sync_tracker_pkg.sv
// rtl/vga_sync_tracker_pkg.sv - default 640x480@60 geometry, tracker states and error bit positions
package vga_sync_tracker_pkg;

  localparam int VGA_H_ADDR      = 640;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_EDGE_POS  = 659;
  localparam int VGA_V_ADDR      = 480;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_EDGE_POS  = 490;
  localparam int VGA_LOCK_FRAMES = 2;

  localparam int ERR_HLEN   = 0;
  localparam int ERR_HWIDTH = 1;
  localparam int ERR_VLEN   = 2;
  localparam int ERR_VWIDTH = 3;

  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    H_TRACK = 2'd1,
    V_TRACK = 2'd2,
    LOCKED  = 2'd3
  } trk_state_e;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchronizer with edge register; idle-high sync pulses
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_i,
  output logic fall_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= sync_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign fall_o = prev_q & ~sync_q;
  assign rise_o = ~prev_q & sync_q;

endmodule

// File: rtl/vga_sync_tracker.sv
// rtl/vga_sync_tracker.sv - recovers hpos/vpos/display_on from incoming hsync/vsync and checks geometry
module vga_sync_tracker
  import vga_sync_tracker_pkg::*;
#(
  parameter int H_ADDR      = VGA_H_ADDR,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_EDGE_POS  = VGA_H_EDGE_POS,
  parameter int V_ADDR      = VGA_V_ADDR,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_EDGE_POS  = VGA_V_EDGE_POS,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       err_clear,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       locked,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic [3:0] err
);

  localparam logic [9:0] H_ADDR_W  = 10'(H_ADDR);
  localparam logic [9:0] H_TOTAL_W = 10'(H_TOTAL);
  localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
  localparam logic [9:0] H_EDGE_W  = 10'(H_EDGE_POS);
  localparam logic [9:0] V_ADDR_W  = 10'(V_ADDR);
  localparam logic [9:0] V_TOTAL_W = 10'(V_TOTAL);
  localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
  localparam logic [9:0] V_EDGE_W  = 10'(V_EDGE_POS);
  localparam logic [3:0] LOCK_W    = 4'(LOCK_FRAMES);

  trk_state_e state_q, state_d;
  logic [9:0] pcnt_q, pcnt_d, lcnt_q, lcnt_d;
  logic [9:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic [9:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic [3:0] err_q, err_d, cfr_q, cfr_d;
  logic       vf_pend_q, vf_pend_d, vr_pend_q, vr_pend_d;

  logic       h_fall, h_rise, v_fall, v_rise;
  logic       tracking, v_checked, vf_now, vr_now, hwrap;
  logic [9:0] pcnt_inc, lcnt_inc;
  logic [3:0] fail_vec;

  sync_edge_detect u_hsync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sync_i (hsync_in),
    .fall_o (h_fall),
    .rise_o (h_rise)
  );

  sync_edge_detect u_vsync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sync_i (vsync_in),
    .fall_o (v_fall),
    .rise_o (v_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SEARCH;
      pcnt_q        <= '0;
      lcnt_q        <= '0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      err_q         <= '0;
      cfr_q         <= '0;
      vf_pend_q     <= 1'b0;
      vr_pend_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pcnt_q        <= pcnt_d;
      lcnt_q        <= lcnt_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      err_q         <= err_d;
      cfr_q         <= cfr_d;
      vf_pend_q     <= vf_pend_d;
      vr_pend_q     <= vr_pend_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lcnt_d        = lcnt_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    cfr_d         = cfr_q;
    vf_pend_d     = vf_pend_q;
    vr_pend_d     = vr_pend_q;
    fail_vec      = '0;

    tracking  = (state_q != SEARCH);
    v_checked = (state_q == V_TRACK) || (state_q == LOCKED);
    pcnt_inc  = sat_inc(pcnt_q);
    lcnt_inc  = sat_inc(lcnt_q);
    vf_now    = vf_pend_q | v_fall;
    vr_now    = vr_pend_q | v_rise;
    hwrap     = (hpos_q >= H_TOTAL_W - 10'd1);

    hpos_d = hwrap ? 10'd0 : hpos_q + 10'd1;
    vpos_d = vpos_q;
    if (hwrap) begin
      vpos_d = (vpos_q >= V_TOTAL_W - 10'd1) ? 10'd0 : vpos_q + 10'd1;
    end
    pcnt_d = pcnt_inc;

    // pcnt+1 at the rise edge equals the low width, as the rise shares the fall's pipeline delay
    if (h_rise && tracking && (pcnt_inc != H_SYNC_W)) begin
      fail_vec[ERR_HWIDTH] = 1'b1;
    end

    if (h_fall) begin
      line_len_d = pcnt_inc;
      pcnt_d     = '0;
      hpos_d     = H_EDGE_W;
      lcnt_d     = lcnt_inc;
      vf_pend_d  = 1'b0;
      vr_pend_d  = 1'b0;
      if (tracking && (pcnt_inc != H_TOTAL_W)) begin
        fail_vec[ERR_HLEN] = 1'b1;
      end
      if (state_q == SEARCH) begin
        state_d = H_TRACK;
      end
      if (vr_now && v_checked && (lcnt_q != V_SYNC_W)) begin
        fail_vec[ERR_VWIDTH] = 1'b1;
      end
      // vsync edges take effect on this line boundary; lcnt restarts at 1 for the fall line
      if (vf_now) begin
        frame_lines_d = lcnt_q;
        lcnt_d        = 10'd1;
        vpos_d        = V_EDGE_W;
        if (state_q == H_TRACK) begin
          state_d = V_TRACK;
          cfr_d   = '0;
        end else if (v_checked) begin
          if (lcnt_q != V_TOTAL_W) begin
            fail_vec[ERR_VLEN] = 1'b1;
          end else if (cfr_q + 4'd1 >= LOCK_W) begin
            state_d = LOCKED;
            cfr_d   = LOCK_W;
          end else begin
            cfr_d = cfr_q + 4'd1;
          end
        end
      end
    end else begin
      if (v_fall) vf_pend_d = 1'b1;
      if (v_rise) vr_pend_d = 1'b1;
      if (tracking && (pcnt_q == CNT_MAX)) begin
        fail_vec[ERR_HLEN] = 1'b1;
      end
    end

    err_d = (err_clear ? 4'd0 : err_q) | fail_vec;
    if (|fail_vec) begin
      state_d = SEARCH;
      cfr_d   = '0;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign locked      = (state_q == LOCKED);
  assign display_on  = locked && (hpos_q < H_ADDR_W) && (vpos_q < V_ADDR_W);
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign err         = err_q;

endmodule
